uart_rx_bridge: RTL and testbench

- Sits between a uart receiver and the data-memory write port, alongside the memory arbiter.
- Acknowledges each received byte and buffers it in a small FIFO.
- Drains buffered bytes into a circular region of data memory, only in cycles when the CPU MEM stage is not using the memory.
- Replaces per-byte stalling of the UART with buffered, opportunistic writes.

---
 rtl/uart_rx_bridge.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_bridge.sv
// UART receive bridge: acknowledges UART bytes, buffers them and drains them into a data-memory ring.
// Latency: a byte latched at edge N can be written to memory at edge N+1 at the earliest.
// Backpressure: cpuMemBusy blocks draining. Bytes that arrive while the FIFO is full (with no pop) are dropped and flagged.

// Small generic FIFO: push/pop in one edge is always legal when count is nonzero.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; contents are discarded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

// Top level: three-state capture FSM, the buffering FIFO, and opportunistic drain into the ring.
module uart_rx_bridge #(
  parameter int               DEPTH     = 8,
  parameter int               ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h40,
  parameter int               RING_LEN  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rxReady,
  input  logic [7:0]               rxData,
  output logic                     rxClear,
  input  logic                     cpuMemBusy,
  output logic                     memWren,
  output logic [ADDR_W-1:0]        memAddr,
  output logic [31:0]              memData,
  output logic [ADDR_W-1:0]        ringPtr,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     overflow,
  input  logic                     ptrClear
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ring_ptr_q, ring_ptr_d;
  logic              overflow_q, overflow_d;

  logic              capture;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [7:0]        head;
  logic [CW-1:0]     count;

  // A capture happens on the IDLE edge that sees rxReady; it is either a push or a drop
  assign capture   = (state_q == ST_IDLE) && rxReady;
  assign fifo_full = (count == CW'(DEPTH));
  assign pop       = (count != '0) && !cpuMemBusy;
  assign push      = capture && (!fifo_full || pop);
  assign drop      = capture && fifo_full && !pop;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (rxData),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  // Capture FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Capture FSM next state: WAIT_LOW guards against re-capturing a slow-clearing uart
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rxReady) state_d = ST_ACK;
      ST_ACK:      state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!rxReady) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Capture FSM outputs: acknowledge pulse is purely a function of state
  always_comb begin
    rxClear = (state_q == ST_ACK);
  end

  // Ring pointer and sticky overflow; ptrClear beats a concurrent pointer increment
  always_comb begin
    ring_ptr_d = ring_ptr_q;
    overflow_d = overflow_q;
    if (pop)  ring_ptr_d = (ring_ptr_q + ADDR_W'(1)) & ADDR_W'(RING_LEN - 1);
    if (drop) overflow_d = 1'b1;
    if (ptrClear) begin
      ring_ptr_d = '0;
      overflow_d = 1'b0;
    end
  end

  // Drain-side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_ptr_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ring_ptr_q <= ring_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Memory write port: data is forced to zero while nothing is buffered so stale slots never show
  always_comb begin
    memWren = pop;
    memAddr = BASE_ADDR + ring_ptr_q;
    memData = (count != '0) ? {{24{head[7]}}, head} : 32'h0;
  end

  assign ringPtr   = ring_ptr_q;
  assign fifoCount = count;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_uart_rx_bridge.sv
module tb_uart_rx_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxReady = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxClear;
  logic        cpuMemBusy = 1'b0;
  logic        memWren;
  logic [7:0]  memAddr;
  logic [31:0] memData;
  logic [7:0]  ringPtr;
  logic [3:0]  fifoCount;
  logic        overflow;
  logic        ptrClear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_clr = 0;

  logic [39:0] exp_q[$];

  uart_rx_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .rxReady    (rxReady),
    .rxData     (rxData),
    .rxClear    (rxClear),
    .cpuMemBusy (cpuMemBusy),
    .memWren    (memWren),
    .memAddr    (memAddr),
    .memData    (memData),
    .ringPtr    (ringPtr),
    .fifoCount  (fifoCount),
    .overflow   (overflow),
    .ptrClear   (ptrClear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_write(input logic [7:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Scoreboard monitor: every write cycle must match the next expected write
  always @(negedge clk) begin
    if (!rst) begin
      if (rxClear) n_clr++;
      if (memWren) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: addr %h data %h, none expected", memAddr, memData);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          if ({memAddr, memData} !== e) begin
            n_bad++;
            $display("FAIL write: got addr %h data %h expected addr %h data %h",
                     memAddr, memData, e[39:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // UART model: holds rxReady until acknowledged, then an optional extra hold
  task automatic send_byte(input logic [7:0] b, input int hold);
    bit seen;
    seen = 0;
    rxData  = b;
    rxReady = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (rxClear) seen = 1;
    end
    if (!seen) check("rxclear_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) step();
    rxReady = 1'b0;
    step();
    step();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && fifoCount != 0; i++) step();
    check("drain_done", {28'd0, fifoCount}, 32'd0);
  endtask

  task automatic pulse_ptr_clear();
    ptrClear = 1'b1;
    step();
    ptrClear = 1'b0;
  endtask

  initial begin
    int clr0;
    logic [7:0] b;
    #2;
    check("reset_wren",     {31'd0, memWren},   32'd0);
    check("reset_rxclear",  {31'd0, rxClear},   32'd0);
    check("reset_count",    {28'd0, fifoCount}, 32'd0);
    check("reset_ringptr",  {24'd0, ringPtr},   32'd0);
    check("reset_overflow", {31'd0, overflow},  32'd0);
    check("reset_addr",     {24'd0, memAddr},   32'h40);
    check("reset_data",     memData,            32'd0);
    step();
    rst = 1'b0;
    step();

    // Single byte
    clr0 = n_clr;
    exp_write(8'h40, 32'h00000041);
    send_byte(8'h41, 0);
    wait_drain();
    check("single_clr_pulses", n_clr - clr0, 32'd1);
    check("single_ringptr", {24'd0, ringPtr}, 32'd1);

    // Sign extension while the CPU holds memory
    cpuMemBusy = 1'b1;
    exp_write(8'h41, 32'hFFFFFFC3);
    send_byte(8'hC3, 0);
    for (int i = 0; i < 5; i++) begin
      check("busy_wren",  {31'd0, memWren},   32'd0);
      check("busy_count", {28'd0, fifoCount}, 32'd1);
      step();
    end
    cpuMemBusy = 1'b0;
    #1;
    check("unblock_wren", {31'd0, memWren}, 32'd1);
    check("unblock_data", memData, 32'hFFFFFFC3);
    wait_drain();
    check("signext_ringptr", {24'd0, ringPtr}, 32'd2);

    // Overflow: ninth byte is dropped
    pulse_ptr_clear();
    check("ptrclear_ringptr", {24'd0, ringPtr}, 32'd0);
    cpuMemBusy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      b = 8'(k);
      if (k <= 8) exp_write(8'h3F + 8'(k), {24'd0, b});
      send_byte(b, 0);
      if (k == 8) check("ovf_not_yet", {31'd0, overflow}, 32'd0);
    end
    check("ovf_count", {28'd0, fifoCount}, 32'd8);
    check("ovf_flag",  {31'd0, overflow},  32'd1);
    cpuMemBusy = 1'b0;
    wait_drain();
    check("ovf_sticky",  {31'd0, overflow}, 32'd1);
    check("ovf_ringptr", {24'd0, ringPtr},  32'd8);
    pulse_ptr_clear();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Ring wrap with memory idle: 17 bytes, 16th to 0x4F, 17th to 0x40
    for (int k = 1; k <= 17; k++) begin
      b = 8'h70 + 8'(k * 3);
      exp_write((k == 17) ? 8'h40 : 8'h3F + 8'(k), {{24{b[7]}}, b});
      send_byte(b, 0);
    end
    wait_drain();
    check("wrap_ringptr", {24'd0, ringPtr}, 32'd1);

    // ptrClear with a concurrent pop: popped byte goes to the old address
    cpuMemBusy = 1'b1;
    exp_write(8'h41, 32'hFFFFFFAA);
    exp_write(8'h40, 32'h00000055);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    cpuMemBusy = 1'b0;
    ptrClear   = 1'b1;
    step();
    ptrClear   = 1'b0;
    check("ptrclr_pop_ringptr", {24'd0, ringPtr},   32'd0);
    check("ptrclr_pop_count",   {28'd0, fifoCount}, 32'd1);
    wait_drain();
    check("ptrclr_final_ringptr", {24'd0, ringPtr}, 32'd1);

    // Held rxReady: one push and one acknowledge only
    cpuMemBusy = 1'b1;
    clr0 = n_clr;
    exp_write(8'h41, 32'h0000005A);
    send_byte(8'h5A, 6);
    check("held_count",  {28'd0, fifoCount}, 32'd1);
    check("held_pulses", n_clr - clr0,       32'd1);
    cpuMemBusy = 1'b0;
    wait_drain();

    // Async reset mid-drain with three bytes buffered
    cpuMemBusy = 1'b1;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    check("prerst_count", {28'd0, fifoCount}, 32'd3);
    cpuMemBusy = 1'b0;
    #1;
    check("prerst_wren", {31'd0, memWren}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_wren",     {31'd0, memWren},   32'd0);
    check("rst_rxclear",  {31'd0, rxClear},   32'd0);
    check("rst_count",    {28'd0, fifoCount}, 32'd0);
    check("rst_ringptr",  {24'd0, ringPtr},   32'd0);
    check("rst_overflow", {31'd0, overflow},  32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_idle_wren", {31'd0, memWren}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
